// File: rtl/xs_fpga_rst_seq.sv
// Board-level reset sequencer: PERST# release, DDR calibration wait,
// device/PHY release and button-gated CPU release, with calibration fault.
module xs_fpga_rst_seq #(
    parameter int CNT_W         = 24,
    parameter int PERST_DLY     = 1000000,
    parameter int CALIB_TIMEOUT = 8000000,
    parameter int DEBOUNCE_CYC  = 200000,
    parameter bit AUTO_BOOT     = 1'b0
) (
    input  logic       sys_clk_i,
    input  logic       sys_rstn,
    input  logic       sw_rstn,
    input  logic       cpu_btn,
    input  logic       calib_done,
    output logic       perst_n,
    output logic       dev_rstn,
    output logic       cpu_rstn,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_PERST = 3'd1,
        S_CALIB = 3'd2,
        S_DEV   = 3'd3,
        S_WAIT  = 3'd4,
        S_RUN   = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] PERST_LAST = CNT_W'(PERST_DLY - 1);
    localparam logic [CNT_W-1:0] CAL_LAST   = CNT_W'(CALIB_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sw_sync;
    logic [1:0]       btn_sync;
    logic [1:0]       cal_sync;
    logic             sw_s;
    logic             btn_s;
    logic             cal_s;

    logic             db;
    logic             btn_rflag;
    logic [CNT_W-1:0] dcnt;

    state_t           cur;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;

    logic             perst_d;
    logic             dev_d;
    logic             cpu_d;
    logic             fault_d;

    always_ff @(posedge sys_clk_i or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sw_sync  <= '0;
            btn_sync <= '0;
            cal_sync <= '0;
        end else begin
            sw_sync  <= {sw_sync[0], sw_rstn};
            btn_sync <= {btn_sync[0], cpu_btn};
            cal_sync <= {cal_sync[0], calib_done};
        end
    end

    assign sw_s  = sw_sync[1];
    assign btn_s = btn_sync[1];
    assign cal_s = cal_sync[1];

    // btn_rflag is raised on the same edge db goes high, so it is a clean 1-cycle pulse
    always_ff @(posedge sys_clk_i or negedge sys_rstn) begin
        if (!sys_rstn) begin
            db        <= 1'b0;
            dcnt      <= '0;
            btn_rflag <= 1'b0;
        end else begin
            btn_rflag <= 1'b0;
            if (btn_s == db) begin
                dcnt <= '0;
            end else if (dcnt == DB_LAST) begin
                db        <= btn_s;
                dcnt      <= '0;
                btn_rflag <= btn_s;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_RST:   if (sw_s) nxt = S_PERST;
            S_PERST: if (cnt == PERST_LAST) nxt = S_CALIB;
            S_CALIB: begin
                if (cal_s)
                    nxt = S_DEV;
                else if (cnt == CAL_LAST)
                    nxt = S_FAULT;
            end
            S_DEV:   nxt = AUTO_BOOT ? S_RUN : S_WAIT;
            S_WAIT:  if (btn_rflag) nxt = S_RUN;
            S_RUN:   if (!cal_s) nxt = S_FAULT;
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_RST;
        endcase
        if (!sw_s)
            nxt = S_RST;
    end

    // Outputs decoded from the next state so they move on the same edge as state
    always_comb begin
        perst_d = 1'b0;
        dev_d   = 1'b0;
        cpu_d   = 1'b0;
        fault_d = 1'b0;
        case (nxt)
            S_CALIB: perst_d = 1'b1;
            S_DEV, S_WAIT: begin
                perst_d = 1'b1;
                dev_d   = 1'b1;
            end
            S_RUN: begin
                perst_d = 1'b1;
                dev_d   = 1'b1;
                cpu_d   = 1'b1;
            end
            S_FAULT: begin
                perst_d = perst_n;
                fault_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn) begin
        if (!sys_rstn) begin
            cur      <= S_RST;
            cnt      <= '0;
            perst_n  <= 1'b0;
            dev_rstn <= 1'b0;
            cpu_rstn <= 1'b0;
            fault    <= 1'b0;
        end else begin
            cur      <= nxt;
            perst_n  <= perst_d;
            dev_rstn <= dev_d;
            cpu_rstn <= cpu_d;
            fault    <= fault_d;
            if (nxt != cur)
                cnt <= '0;
            else if (cnt != {CNT_W{1'b1}})
                cnt <= cnt + 1'b1;
        end
    end

    assign state = cur;

endmodule
